// File: rtl/rvv_backend_decode_ctrl.sv
// rvv_backend_decode_ctrl: gates the CQ head into decode, accepts a contiguous uop prefix into the Uops Queue,
// pops the CQ on the final uop, and drops/counts commands that decode to no uops.
module rvv_backend_decode_ctrl #(
    parameter int NUM_DE_UOP      = 4,
    parameter int UOP_INDEX_WIDTH = 3,
    parameter int UQ_FREE_WIDTH   = 4,
    parameter int DROP_CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cq_valid,
    output logic                       inst_valid_cq2de,
    output logic                       pop_de2cq,
    output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
    input  logic [NUM_DE_UOP-1:0]      uop_valid_de2uq,
    input  logic [NUM_DE_UOP-1:0]      uop_last_de2uq,
    input  logic [UQ_FREE_WIDTH-1:0]   uq_free,
    output logic [NUM_DE_UOP-1:0]      uop_push_de2uq,
    input  logic                       trap_flush,
    output logic [DROP_CNT_WIDTH-1:0]  drop_cnt
);
    localparam int CW = $clog2(NUM_DE_UOP + 1);
    logic [CW-1:0] v, n;
    logic gap, last_acc, drop;
    assign inst_valid_cq2de = cq_valid & ~trap_flush;
    always_comb begin
        v = '0;
        gap = 1'b0;
        last_acc = 1'b0;
        uop_push_de2uq = '0;
        for (int i = 0; i < NUM_DE_UOP; i++) begin
            if (!gap && uop_valid_de2uq[i]) v = CW'(i + 1);
            else gap = 1'b1;
        end
        n = (32'(v) > 32'(uq_free)) ? CW'(uq_free) : v;
        for (int i = 0; i < NUM_DE_UOP; i++) begin
            uop_push_de2uq[i] = inst_valid_cq2de && (i < int'(n));
            last_acc = last_acc | (uop_push_de2uq[i] & uop_last_de2uq[i]);
        end
    end
    // a full Uops Queue stalls everything, drops included
    assign drop = inst_valid_cq2de && (v == '0) && (uop_index_remain == '0) && (uq_free != '0);
    assign pop_de2cq = inst_valid_cq2de && (last_acc || drop);
    always_ff @(posedge clk) begin
        if (rst) begin
            uop_index_remain <= '0;
            drop_cnt <= '0;
        end else begin
            if (trap_flush || pop_de2cq) uop_index_remain <= '0;
            else if (inst_valid_cq2de) uop_index_remain <= uop_index_remain + UOP_INDEX_WIDTH'(n);
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && inst_valid_cq2de) begin
            assert ((uop_valid_de2uq & ~((NUM_DE_UOP)'((1 << v) - 1))) == '0)
                else $warning("decode_ctrl: valid lane above a gap, lanes ignored");
            assert (((uop_last_de2uq & uop_push_de2uq) == '0) ||
                    ((uop_last_de2uq & uop_push_de2uq) == (uop_push_de2uq & ~(uop_push_de2uq >> 1))))
                else $error("decode_ctrl: last flag not on highest accepted lane");
            assert (!(v == '0 && uop_index_remain != '0))
                else $error("decode_ctrl: no uops mid-instruction");
            assert (pop_de2cq || (int'(uop_index_remain) + int'(n) <= (1 << UOP_INDEX_WIDTH) - 1))
                else $error("decode_ctrl: uop index overflow");
        end
    end
endmodule

// File: tb/tb_rvv_backend_decode_ctrl.sv
// tb_rvv_backend_decode_ctrl: scoreboard bench; expectations queued at drive time, compared at the falling edge.
module tb_rvv_backend_decode_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cq_valid = 1'b0;
    logic       inst_valid_cq2de, pop_de2cq, trap_flush = 1'b0;
    logic [2:0] uop_index_remain;
    logic [3:0] uop_valid_de2uq = '0, uop_last_de2uq = '0, uop_push_de2uq;
    logic [3:0] uq_free = '0;
    logic [7:0] drop_cnt;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic       ival;
        logic [3:0] push;
        logic       pop;
        logic [2:0] rem;
        logic [7:0] drop;
    } exp_t;
    exp_t sb[$];

    rvv_backend_decode_ctrl dut (
        .clk(clk), .rst(rst), .cq_valid(cq_valid), .inst_valid_cq2de(inst_valid_cq2de),
        .pop_de2cq(pop_de2cq), .uop_index_remain(uop_index_remain), .uop_valid_de2uq(uop_valid_de2uq),
        .uop_last_de2uq(uop_last_de2uq), .uq_free(uq_free), .uop_push_de2uq(uop_push_de2uq),
        .trap_flush(trap_flush), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle and queue the values the DUT must show during it
    task automatic step(input logic r, input logic cq, input logic fl, input logic [3:0] val,
                        input logic [3:0] lst, input logic [3:0] free, input logic [3:0] e_push,
                        input logic e_pop, input logic [2:0] e_rem, input logic [7:0] e_drop);
        @(posedge clk);
        #1;
        rst = r; cq_valid = cq; trap_flush = fl;
        uop_valid_de2uq = val; uop_last_de2uq = lst; uq_free = free;
        sb.push_back('{ival: cq & ~fl, push: e_push, pop: e_pop, rem: e_rem, drop: e_drop});
    endtask

    task automatic idle(input logic [2:0] e_rem, input logic [7:0] e_drop);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd15, 4'b0000, 1'b0, e_rem, e_drop);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ival", 32'(inst_valid_cq2de), 32'(e.ival));
                check("push", 32'(uop_push_de2uq), 32'(e.push));
                check("pop", 32'(pop_de2cq), 32'(e.pop));
                check("remain", 32'(uop_index_remain), 32'(e.rem));
                check("drop_cnt", 32'(drop_cnt), 32'(e.drop));
            end
        end
    end

    initial begin
        int budget;
        repeat (2) @(posedge clk);
        idle(3'd0, 8'd0);
        // 8-uop instruction in two cycles
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'd15, 4'b1111, 1'b0, 3'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 4'd15, 4'b1111, 1'b1, 3'd4, 8'd0);
        idle(3'd0, 8'd0);
        // back-pressure on a 3-uop instruction
        step(1'b0, 1'b1, 1'b0, 4'b0111, 4'b0100, 4'd1, 4'b0001, 1'b0, 3'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 4'd0, 4'b0000, 1'b0, 3'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 4'd5, 4'b0011, 1'b1, 3'd1, 8'd0);
        idle(3'd0, 8'd0);
        // drops, then run the counter into saturation
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'd15, 4'b0000, 1'b1, 3'd0, 8'(i > 255 ? 255 : i));
        idle(3'd0, 8'd255);
        // flush mid-instruction
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'd15, 4'b1111, 1'b0, 3'd0, 8'd255);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0010, 4'd15, 4'b0000, 1'b0, 3'd4, 8'd255);
        idle(3'd0, 8'd255);
        // non-contiguous valids: only the leading prefix is taken
        step(1'b0, 1'b1, 1'b0, 4'b1011, 4'b0000, 4'd8, 4'b0011, 1'b0, 3'd0, 8'd255);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd8, 4'b0000, 1'b0, 3'd2, 8'd255);
        step(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 4'd8, 4'b0011, 1'b1, 3'd2, 8'd255);
        idle(3'd0, 8'd255);
        // reset mid-instruction
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'd15, 4'b1111, 1'b0, 3'd0, 8'd255);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'd15, 4'b0000, 1'b0, 3'd4, 8'd255);
        idle(3'd0, 8'd0);
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
